// File: rtl/mips_mc_pkg.sv
// Purpose: shared constants for the multi-cycle MIPS controller (opcodes, ALU codes, states, mux selects).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_mc_pkg;

  localparam int STATE_W_DEF = 4;

  // IR[31:26] opcodes understood by the controller
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;

  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_NONE  = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Quiescent control word: no strobes, all selects 00, ALU idle
  localparam ctrl_t CTRL_IDLE = '{
    pc_write: 1'b0, ir_write: 1'b0, i_or_d: 1'b0, mem_read: 1'b0,
    mem_write: 1'b0, mem_to_reg: 2'b00, reg_dst: 2'b00, reg_write: 1'b0,
    alu_src_a: 1'b0, alu_src_b: 2'b00, alu_op: ALU_NONE, pc_src: 2'b00,
    instr_done: 1'b0, illegal_op: 1'b0
  };

  // Where DECODE dispatches each opcode; anything unknown halts the core
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_R_TYPE, OP_ADDI, OP_LUI, OP_ORI, OP_ANDI: return S_EXECUTE;
      OP_LW, OP_SW:                                return S_MEM_ADDR;
      OP_BEQ, OP_BNE:                              return S_BRANCH;
      OP_J, OP_JAL:                                return S_JUMP;
      default:                                     return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Purpose: controller <-> datapath bundle: status into the FSM, mux selects and strobes out.
// Latency: n/a (wiring only).
// Backpressure: mem_ready_i stalls the controller in its memory-access states.
// Ports: master = controller (drives *_o), slave = datapath/memory side (drives *_i).
interface multi_cycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode_i;
  logic               zero_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               ir_write_o;
  logic               i_or_d_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic [1:0]         mem_to_reg_o;
  logic [1:0]         reg_dst_o;
  logic               reg_write_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [2:0]         alu_op_o;
  logic [1:0]         pc_src_o;
  logic               instr_done_o;
  logic               illegal_op_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, instr_done_o, illegal_op_o, state_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
           mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_src_o, instr_done_o, illegal_op_o, state_o
  );
endinterface

// File: rtl/mc_output_decode.sv
// Purpose: combinational control word for the current FSM step.
// Latency: 0 cycles (pure combinational).
// Backpressure: mem_ready_i gates IR/PC load in FETCH and the done pulse in MEM_WRITE.
// Ports: state/op_q from the sequencer, zero_i/mem_ready_i from datapath, ctrl = full control word.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl
);

  logic is_rtype;
  assign is_rtype = (op_q == OP_R_TYPE);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        // PC+4 computed by the ALU while the instruction is read
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // speculative branch target lands in ALUOut
        ctrl.alu_src_b = SRCB_BR;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = WB_MDR;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready_i;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = is_rtype ? SRCB_B : SRCB_IMM;
        case (op_q)
          OP_R_TYPE: ctrl.alu_op = ALU_FUNCT;
          OP_ADDI:   ctrl.alu_op = ALU_ADD;
          OP_LUI:    ctrl.alu_op = ALU_LUI;
          OP_ORI:    ctrl.alu_op = ALU_OR;
          OP_ANDI:   ctrl.alu_op = ALU_AND;
          default:   ctrl.alu_op = ALU_NONE;
        endcase
      end
      S_ALU_WB: begin
        ctrl.reg_dst    = is_rtype ? DST_RD : DST_RT;
        ctrl.mem_to_reg = WB_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PC_ALUOUT;
        ctrl.instr_done = 1'b1;
        ctrl.pc_write   = ((op_q == OP_BEQ) &&  zero_i) ||
                          ((op_q == OP_BNE) && !zero_i);
      end
      S_JUMP: begin
        ctrl.pc_src     = PC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        if (op_q == OP_JAL) begin
          // PC already holds PC+4 here, so it is the link value
          ctrl.reg_dst    = DST_RA;
          ctrl.mem_to_reg = WB_PC;
          ctrl.reg_write  = 1'b1;
        end
      end
      S_HALT: ctrl.illegal_op = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Purpose: sequencing FSM for the multi-cycle MIPS datapath; holds state and latched opcode.
// Latency: R/I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J/JAL 3 cycles plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready_i; HALT exits only via reset.
// Ports: clk, reset (sync, active-low), bus = controller side of multi_cycle_control_if.
module multi_cycle_control
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF
)(
  input logic                   clk,
  input logic                   reset,
  multi_cycle_control_if.master bus
);

  state_t     state;
  logic [5:0] op_q;
  ctrl_t      dec;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      case (state)
        S_FETCH:     if (bus.mem_ready_i) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= bus.opcode_i;
          state <= decode_next(bus.opcode_i);
        end
        S_MEM_ADDR:  state <= (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (bus.mem_ready_i) state <= S_MEM_WB;
        S_MEM_WRITE: if (bus.mem_ready_i) state <= S_FETCH;
        S_EXECUTE:   state <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

  mc_output_decode u_decode (
    .state       (state),
    .op_q        (op_q),
    .zero_i      (bus.zero_i),
    .mem_ready_i (bus.mem_ready_i),
    .ctrl        (dec)
  );

  // Reset must silence the datapath in the same cycle, before the state register clears
  assign ctrl = reset ? dec : CTRL_IDLE;

  assign bus.pc_write_o   = ctrl.pc_write;
  assign bus.ir_write_o   = ctrl.ir_write;
  assign bus.i_or_d_o     = ctrl.i_or_d;
  assign bus.mem_read_o   = ctrl.mem_read;
  assign bus.mem_write_o  = ctrl.mem_write;
  assign bus.mem_to_reg_o = ctrl.mem_to_reg;
  assign bus.reg_dst_o    = ctrl.reg_dst;
  assign bus.reg_write_o  = ctrl.reg_write;
  assign bus.alu_src_a_o  = ctrl.alu_src_a;
  assign bus.alu_src_b_o  = ctrl.alu_src_b;
  assign bus.alu_op_o     = ctrl.alu_op;
  assign bus.pc_src_o     = ctrl.pc_src;
  assign bus.instr_done_o = ctrl.instr_done;
  assign bus.illegal_op_o = ctrl.illegal_op;
  assign bus.state_o      = STATE_W'(state);

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multi_cycle_control_if #(.STATE_W(4)) ifc ();

  multi_cycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  // {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
  //  reg_write, src_a, src_b, alu_op, pc_src, instr_done, illegal_op}
  logic [19:0] obs_vec;
  assign obs_vec = {ifc.pc_write_o, ifc.ir_write_o, ifc.i_or_d_o, ifc.mem_read_o,
                    ifc.mem_write_o, ifc.mem_to_reg_o, ifc.reg_dst_o, ifc.reg_write_o,
                    ifc.alu_src_a_o, ifc.alu_src_b_o, ifc.alu_op_o, ifc.pc_src_o,
                    ifc.instr_done_o, ifc.illegal_op_o};

  localparam logic [19:0] NO_ALU_MASK = 20'hFFF8F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference control word per datapath step, straight from the step descriptions
  function automatic logic [19:0] exp_out(input int st, input logic [5:0] op,
                                          input logic z, input logic r);
    logic pcw, irw, iod, mr, mw, rw, sa, done, ill;
    logic [1:0] m2r, rd, sb, ps;
    logic [2:0] alu;
    pcw = 0; irw = 0; iod = 0; mr = 0; mw = 0; rw = 0; sa = 0; done = 0; ill = 0;
    m2r = 0; rd = 0; sb = 0; ps = 0; alu = 3'b101;
    case (st)
      0:  begin mr = 1; sb = 2'b01; alu = 3'b100; irw = r; pcw = r; end
      1:  begin sb = 2'b11; alu = 3'b100; end
      2:  begin sa = 1; sb = 2'b10; alu = 3'b100; end
      3:  begin iod = 1; mr = 1; end
      4:  begin m2r = 2'b01; rw = 1; done = 1; end
      5:  begin iod = 1; mw = 1; done = r; end
      6:  begin
            sa = 1;
            sb = (op == 6'h00) ? 2'b00 : 2'b10;
            case (op)
              6'h00: alu = 3'b111;
              6'h08: alu = 3'b100;
              6'h0F: alu = 3'b000;
              6'h0D: alu = 3'b001;
              default: alu = 3'b010;
            endcase
          end
      7:  begin rd = (op == 6'h00) ? 2'b01 : 2'b00; rw = 1; done = 1; end
      8:  begin sa = 1; alu = 3'b011; ps = 2'b01; done = 1; pcw = (op == 6'h04) ? z : ~z; end
      9:  begin
            ps = 2'b10; pcw = 1; done = 1;
            if (op == 6'h03) begin rd = 2'b10; m2r = 2'b10; rw = 1; end
          end
      10: ill = 1;
      default: ;
    endcase
    return {pcw, irw, iod, mr, mw, m2r, rd, rw, sa, sb, alu, ps, done, ill};
  endfunction

  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h0F, 6'h0D, 6'h0C: return 4;
      6'h23:                             return 5;
      6'h2B:                             return 4;
      default:                           return 3;
    endcase
  endfunction

  // One instruction: build the expected step list, drive it, compare every cycle.
  // Entered and left at posedge+1.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic zb);
    int st_q[$];
    logic rdy_q[$];
    int done_cnt, done_at, exp_lat;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
    st_q.push_back(0); rdy_q.push_back(1'b1);
    st_q.push_back(1); rdy_q.push_back(1'($urandom));
    case (op)
      6'h23, 6'h2B: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin
          st_q.push_back(op == 6'h23 ? 3 : 5); rdy_q.push_back(1'b0);
        end
        st_q.push_back(op == 6'h23 ? 3 : 5); rdy_q.push_back(1'b1);
        if (op == 6'h23) begin st_q.push_back(4); rdy_q.push_back(1'($urandom)); end
      end
      6'h04, 6'h05: begin st_q.push_back(8); rdy_q.push_back(1'($urandom)); end
      6'h02, 6'h03: begin st_q.push_back(9); rdy_q.push_back(1'($urandom)); end
      default: begin
        st_q.push_back(6); rdy_q.push_back(1'($urandom));
        st_q.push_back(7); rdy_q.push_back(1'($urandom));
      end
    endcase
    exp_lat = base_latency(op) + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0);
    done_cnt = 0;
    done_at = -1;
    for (int i = 0; i < st_q.size(); i++) begin
      ifc.opcode_i    = (st_q[i] == 1) ? op : 6'($urandom);
      ifc.zero_i      = (st_q[i] == 8) ? zb : 1'($urandom);
      ifc.mem_ready_i = rdy_q[i];
      @(negedge clk);
      chk($sformatf("state op%02h c%0d", op, i), 32'(ifc.state_o), 32'(st_q[i]));
      chk($sformatf("ctrl op%02h c%0d", op, i), 32'(obs_vec),
          32'(exp_out(st_q[i], op, ifc.zero_i, ifc.mem_ready_i)));
      if (ifc.instr_done_o) begin done_cnt++; done_at = i + 1; end
      @(posedge clk); #1;
    end
    chk($sformatf("done_count op%02h", op), 32'(done_cnt), 32'd1);
    chk($sformatf("latency op%02h", op), 32'(done_at), 32'(exp_lat));
  endtask

  logic [5:0] legal_ops [11] = '{6'h00, 6'h08, 6'h0F, 6'h0D, 6'h0C, 6'h23,
                                 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  initial begin
    ifc.opcode_i = 6'h00;
    ifc.zero_i = 1'b0;
    ifc.mem_ready_i = 1'b1;

    // Reset: outputs silenced while low, FETCH right after release
    reset = 1'b0;
    @(negedge clk);
    chk("reset strobes", 32'(obs_vec & NO_ALU_MASK), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset state", 32'(ifc.state_o), 32'd0);
    chk("post-reset fetch", 32'(obs_vec), 32'(exp_out(0, 6'h00, ifc.zero_i, 1'b1)));
    @(posedge clk); #1;
    // that FETCH saw ready=1, so DECODE is next; finish it as an R-type
    ifc.opcode_i = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Directed cases
    run_instr(6'h08, 0, 0, 1'b0);   // ADDI
    run_instr(6'h23, 0, 2, 1'b0);   // LW, 2 wait states in MEM_READ
    run_instr(6'h04, 0, 0, 1'b1);   // BEQ taken
    run_instr(6'h04, 0, 0, 1'b0);   // BEQ not taken
    run_instr(6'h05, 0, 0, 1'b1);   // BNE not taken
    run_instr(6'h05, 0, 0, 1'b0);   // BNE taken
    run_instr(6'h03, 0, 0, 1'b0);   // JAL
    run_instr(6'h02, 0, 0, 1'b0);   // J
    run_instr(6'h00, 1, 0, 1'b0);   // R-type with a fetch wait
    run_instr(6'h2B, 2, 1, 1'b0);   // SW with fetch and write waits

    // Random instruction stream
    for (int k = 0; k < 40; k++) begin
      run_instr(legal_ops[$urandom_range(10, 0)], int'($urandom_range(2, 0)),
                int'($urandom_range(3, 0)), 1'($urandom));
    end

    // Illegal opcode halts until reset
    ifc.mem_ready_i = 1'b1;
    @(posedge clk); #1;               // FETCH -> DECODE
    ifc.opcode_i = 6'h3F;
    @(negedge clk);
    chk("halt decode state", 32'(ifc.state_o), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      ifc.opcode_i = 6'($urandom);
      ifc.mem_ready_i = 1'($urandom);
      ifc.zero_i = 1'($urandom);
      @(negedge clk);
      chk($sformatf("halt state c%0d", i), 32'(ifc.state_o), 32'd10);
      chk($sformatf("halt ctrl c%0d", i), 32'(obs_vec), 32'(exp_out(10, 6'h3F, 1'b0, 1'b0)));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("halt reset strobes", 32'(obs_vec & NO_ALU_MASK), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ifc.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("halt exit state", 32'(ifc.state_o), 32'd0);
    chk("halt exit illegal", 32'(ifc.illegal_op_o), 32'd0);
    @(posedge clk); #1;

    // Reset during a MEM_WRITE wait abandons the store
    ifc.mem_ready_i = 1'b1;
    @(posedge clk); #1;               // FETCH -> DECODE
    ifc.opcode_i = 6'h2B;
    @(posedge clk); #1;               // DECODE -> MEM_ADDR
    @(posedge clk); #1;               // MEM_ADDR -> MEM_WRITE
    ifc.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("sw wait state", 32'(ifc.state_o), 32'd5);
    chk("sw wait mem_write", 32'(ifc.mem_write_o), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("sw reset strobes", 32'(obs_vec & NO_ALU_MASK), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("sw reset state", 32'(ifc.state_o), 32'd0);
    chk("sw reset mem_write", 32'(ifc.mem_write_o), 32'd0);
    chk("sw reset mem_read", 32'(ifc.mem_read_o), 32'd1);
    @(posedge clk); #1;
    // still in FETCH (ready was 0); a full instruction confirms recovery
    run_instr(6'h0D, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
